video_fetch: RTL and testbench
==============================

Name: video_fetch

Overview:
- Upstream feeder for the VGA byte buffer.
- Reads BSIZE-byte words sequentially from the frame memory over a req/ack port and keeps one prefetched word in a holding register.
- Issues a one-cycle load pulse with that word whenever the buffer reports empty.
- Wraps at frame end and restarts on a frame-start pulse from the sync generator.

Parameters:
- BSIZE, 4, bytes per word; must match the downstream buffer's bsize.
- ADDR_W, 17, frame memory word-address width.
- FRAME_WORDS, 76800, words per frame (640x480 bytes / 4); last address is FRAME_WORDS-1.

Ports:
- clk25MHz  input  1  pixel clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- frame_start  input  1  one-cycle pulse at start of vertical blank; restarts fetch at address 0.
- mem_req  output  1  read request, held until mem_ack.
- mem_addr  output  ADDR_W  word address; stable while mem_req is high.
- mem_ack  input  1  one-cycle; mem_rdata is valid in the same cycle.
- mem_rdata  input  BSIZE*8  read word; byte 0 = bits [7:0] = first pixel.
- buf_empty  input  1  buffer empty flag.
- buf_load  output  1  one-cycle load pulse to the buffer.
- buf_data  output  BSIZE*8  word presented with buf_load; stable from the load cycle until the next load.
- underrun  output  1  sticky flag, set when buf_empty=1 and no word is held.

Behaviour:
- Reset values: mem_req=0, mem_addr=0, buf_load=0, buf_data=0, underrun=0, hold_valid=0, discard=0, state=IDLE.
- FSM states: IDLE, REQ, HOLD.
- IDLE:
  - If hold_valid=0: go to REQ next cycle and assert mem_req with the current mem_addr.
- REQ:
  - mem_req=1 until the cycle mem_ack=1.
  - On ack: latch mem_rdata into the holding register, set hold_valid=1, advance mem_addr (FRAME_WORDS-1 -> 0, otherwise +1), go to HOLD.
  - The ack arriving in the same cycle as the request is legal; minimum request-to-data latency is 1 cycle.
- HOLD:
  - When buf_empty=1 and buf_load was 0 in the previous cycle: assert buf_load for exactly one cycle, drive buf_data = holding word, clear hold_valid, go to REQ next cycle.
  - Loads are therefore never issued on two consecutive cycles; this is a guard for the buffer's asynchronous clearing of empty.
- Steady-state latency: buf_empty rising (word held) -> buf_load in the next cycle.
- Throughput: one word per (mem latency + 2) cycles at most.
- frame_start:
  - Forces mem_addr=0 and hold_valid=0 (the held word is dropped, no load issued).
  - If in REQ with the ack not yet seen: mem_req stays high (address unchanged) until ack, discard=1, and the acked data is thrown away. The next request then goes out at address 0.
  - frame_start in the same cycle as mem_ack: the data is discarded, mem_addr=0.
  - frame_start in the same cycle as buf_load: the load completes, then the address is reset.
- Underrun: when buf_empty=1 and hold_valid=0 (excluding the cycle after a load), set underrun=1. Cleared only by reset.
- Reset mid-request: mem_req drops immediately (asynchronous). The memory side must tolerate an abandoned request.

Optional Feature:
- Macro: VIDEO_FETCH_UNDERRUN_CNT_EN.
- Defined: adds output underrun_cnt [15:0].
  - Counts underrun cycles, saturating at 16'hFFFF.
  - Cleared by reset and by frame_start (the per-frame count). The sticky underrun flag is unaffected by frame_start.
- Undefined: no counter, no port; only the sticky flag.

Decomposition:
- Shared package vga_pkg holds:
  - FSM state typedef (IDLE/REQ/HOLD).
  - Default constants H_ACTIVE=640, V_ACTIVE=480, BYTES_PER_WORD=4.
  - Derived FRAME_WORDS.
- One sub-module: video_fetch_addr.
  - Wrap-around address counter with clear and advance inputs.
  - Reused by a future write-side frame filler.

Test Plan:
- Reset release, buf_empty=1, mem_ack 2 cycles after mem_req:
  - first mem_addr=0.
  - buf_load exactly 1 cycle after the word is latched; buf_data = mem_rdata.
  - next mem_req at address 1.
- buf_empty held at 1 for 10 cycles while holding word 0xDEADBEEF:
  - exactly one buf_load.
  - no second load on the following cycle.
- Run to address 76799:
  - the next request goes to address 0.
  - no load lost or duplicated across the wrap.
- frame_start while mem_req is pending at address 500:
  - mem_req stays until ack; data 0x11223344 is not loaded.
  - next mem_addr=0.
- frame_start coincident with mem_ack: data discarded, next address 0, hold_valid=0.
- Memory stalled 20 cycles with buf_empty=1:
  - underrun=1 and stays 1 after recovery.
  - with VIDEO_FETCH_UNDERRUN_CNT_EN, underrun_cnt=20, then 0 after frame_start.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA definitions: fetch FSM states and frame geometry constants.
package vga_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD
    } fetch_state_t;

    localparam int H_ACTIVE       = 640;
    localparam int V_ACTIVE       = 480;
    localparam int BYTES_PER_WORD = 4;
    localparam int FRAME_WORDS    = (H_ACTIVE * V_ACTIVE) / BYTES_PER_WORD;

endpackage

// File: rtl/video_fetch_addr.sv
// Wrap-around frame word-address counter with synchronous clear and advance.
module video_fetch_addr
    import vga_pkg::*;
#(
    parameter int ADDR_W     = 17,
    parameter int WRAP_WORDS = FRAME_WORDS
) (
    input  logic              clk25MHz,
    input  logic              reset,
    input  logic              clear,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WRAP_WORDS - 1);

    // Clear wins over advance so a restart never lands on address 1.
    always_ff @(posedge clk25MHz or posedge reset) begin
        if (reset) begin
            addr <= '0;
        end else if (clear) begin
            addr <= '0;
        end else if (advance) begin
            addr <= (addr == LAST_ADDR) ? '0 : addr + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/video_fetch.sv
// Frame-memory prefetcher feeding the VGA byte buffer with one held word.
// Optional macro VIDEO_FETCH_UNDERRUN_CNT_EN adds a per-frame underrun cycle counter.
module video_fetch #(
    parameter int BSIZE       = vga_pkg::BYTES_PER_WORD,
    parameter int ADDR_W      = 17,
    parameter int FRAME_WORDS = vga_pkg::FRAME_WORDS
) (
    input  logic               clk25MHz,
    input  logic               reset,
    input  logic               frame_start,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [BSIZE*8-1:0] mem_rdata,
    input  logic               buf_empty,
    output logic               buf_load,
    output logic [BSIZE*8-1:0] buf_data,
    output logic               underrun
`ifdef VIDEO_FETCH_UNDERRUN_CNT_EN
    ,
    output logic [15:0]        underrun_cnt
`endif
);

    import vga_pkg::*;

    fetch_state_t       state, state_next;
    logic [BSIZE*8-1:0] hold_word;
    logic               hold_valid, hold_valid_next;
    logic               discard, discard_next;
    logic               load_now;
    logic               latch_now;
    logic               addr_clear;
    logic               addr_advance;
    logic               underrun_now;

    video_fetch_addr #(
        .ADDR_W     (ADDR_W),
        .WRAP_WORDS (FRAME_WORDS)
    ) u_addr (
        .clk25MHz (clk25MHz),
        .reset    (reset),
        .clear    (addr_clear),
        .advance  (addr_advance),
        .addr     (mem_addr)
    );

    assign mem_req = (state == REQ);

    // The load cycle itself is not an underrun: the buffer is still clearing empty.
    assign underrun_now = buf_empty && !hold_valid && !buf_load;

    always_comb begin
        state_next      = state;
        hold_valid_next = hold_valid;
        discard_next    = discard;
        load_now        = 1'b0;
        latch_now       = 1'b0;
        addr_clear      = 1'b0;
        addr_advance    = 1'b0;
        case (state)
            IDLE: begin
                if (!hold_valid) begin
                    state_next = REQ;
                end
                if (frame_start) begin
                    addr_clear = 1'b1;
                end
            end
            REQ: begin
                // A restart during an open request waits for the ack, then drops the data.
                if (mem_ack) begin
                    discard_next = 1'b0;
                    if (discard || frame_start) begin
                        addr_clear      = 1'b1;
                        hold_valid_next = 1'b0;
                        state_next      = IDLE;
                    end else begin
                        latch_now       = 1'b1;
                        hold_valid_next = 1'b1;
                        addr_advance    = 1'b1;
                        state_next      = HOLD;
                    end
                end else if (frame_start) begin
                    discard_next = 1'b1;
                end
            end
            HOLD: begin
                if (buf_empty && !buf_load) begin
                    load_now        = 1'b1;
                    hold_valid_next = 1'b0;
                    state_next      = REQ;
                end
                if (frame_start) begin
                    addr_clear      = 1'b1;
                    hold_valid_next = 1'b0;
                    state_next      = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk25MHz or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            hold_word  <= '0;
            hold_valid <= 1'b0;
            discard    <= 1'b0;
            buf_load   <= 1'b0;
            buf_data   <= '0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_next;
            hold_valid <= hold_valid_next;
            discard    <= discard_next;
            buf_load   <= load_now;
            if (latch_now) begin
                hold_word <= mem_rdata;
            end
            if (load_now) begin
                buf_data <= hold_word;
            end
            if (underrun_now) begin
                underrun <= 1'b1;
            end
        end
    end

`ifdef VIDEO_FETCH_UNDERRUN_CNT_EN
    always_ff @(posedge clk25MHz or posedge reset) begin
        if (reset) begin
            underrun_cnt <= '0;
        end else if (frame_start) begin
            underrun_cnt <= '0;
        end else if (underrun_now && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`else
    // Without the counter, the sticky flag is the only underrun report.
`endif

endmodule

// File: tb/tb_video_fetch.sv
// Directed self-checking bench for video_fetch (frame shortened to keep the wrap test quick).
module tb_video_fetch;

    localparam int TB_FRAME_WORDS = 1000;

    logic        clk25MHz = 1'b0;
    logic        reset;
    logic        frame_start;
    logic        mem_req;
    logic [16:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        buf_empty;
    logic        buf_load;
    logic [31:0] buf_data;
    logic        underrun;
`ifdef VIDEO_FETCH_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    int checks = 0;
    int errors = 0;

    video_fetch #(
        .BSIZE       (4),
        .ADDR_W      (17),
        .FRAME_WORDS (TB_FRAME_WORDS)
    ) dut (
        .clk25MHz    (clk25MHz),
        .reset       (reset),
        .frame_start (frame_start),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .buf_empty   (buf_empty),
        .buf_load    (buf_load),
        .buf_data    (buf_data),
        .underrun    (underrun)
`ifdef VIDEO_FETCH_UNDERRUN_CNT_EN
        ,
        .underrun_cnt(underrun_cnt)
`endif
    );

    always #20 clk25MHz = ~clk25MHz;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "[TB] watchdog expired");
    end

    // One bench cycle: inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk25MHz);
    endtask

    // Waits for a request, answers it after 'delay' cycles, returns at the HOLD cycle.
    task automatic fetch_word(input logic [31:0] data, input int delay, output logic [16:0] addr_seen);
        int waited = 0;
        while (mem_req !== 1'b1 && waited < 50) begin
            step();
            waited++;
        end
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fetch_timeout: mem_req=%b required 1", mem_req);
            addr_seen = '0;
            return;
        end
        addr_seen = mem_addr;
        repeat (delay) step();
        mem_ack   = 1'b1;
        mem_rdata = data;
        step();
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        frame_start = 1'b0;
        mem_ack     = 1'b0;
        mem_rdata   = '0;
        buf_empty   = 1'b1;
        repeat (3) step();
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== 17'd0 || buf_load !== 1'b0 ||
            buf_data !== 32'd0 || underrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_values: req=%b addr=%0d load=%b data=%h underrun=%b required 0/0/0/0/0",
                     mem_req, mem_addr, buf_load, buf_data, underrun);
        end
        reset = 1'b0;
    endtask

    task automatic test_first_fetch();
        logic [16:0] a;
        fetch_word(32'h0A0B0C0D, 2, a);
        checks++;
        if (a !== 17'd0) begin
            errors++;
            $display("[TB] FAIL first_addr: got %0d required 0", a);
        end
        checks++;
        if (buf_load !== 1'b0) begin
            errors++;
            $display("[TB] FAIL first_load_early: buf_load=%b required 0", buf_load);
        end
        step();
        checks++;
        if (buf_load !== 1'b1 || buf_data !== 32'h0A0B0C0D) begin
            errors++;
            $display("[TB] FAIL first_load: load=%b data=%h required 1 0a0b0c0d", buf_load, buf_data);
        end
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 17'd1) begin
            errors++;
            $display("[TB] FAIL second_req: req=%b addr=%0d required 1 1", mem_req, mem_addr);
        end
    endtask

    task automatic test_single_load();
        logic [16:0] a;
        int loads = 0;
        buf_empty = 1'b0;
        fetch_word(32'hDEADBEEF, 1, a);
        checks++;
        if (a !== 17'd1) begin
            errors++;
            $display("[TB] FAIL hold_addr: got %0d required 1", a);
        end
        repeat (2) step();
        checks++;
        if (buf_load !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold_idle: load=%b req=%b required 0 0", buf_load, mem_req);
        end
        buf_empty = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (buf_load === 1'b1) loads++;
            if (i == 0) begin
                checks++;
                if (buf_load !== 1'b1 || buf_data !== 32'hDEADBEEF) begin
                    errors++;
                    $display("[TB] FAIL hold_latency: load=%b data=%h required 1 deadbeef", buf_load, buf_data);
                end
            end
            if (i == 1) begin
                checks++;
                if (buf_load !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL back_to_back: buf_load=%b required 0", buf_load);
                end
            end
        end
        checks++;
        if (loads != 1 || buf_data !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL load_count: loads=%0d data=%h required 1 deadbeef", loads, buf_data);
        end
    endtask

    task automatic test_stream(input int start, input int n);
        logic [16:0] a;
        logic [31:0] word;
        int          exp_addr;
        for (int i = 0; i < n; i++) begin
            exp_addr = (start + i) % TB_FRAME_WORDS;
            word     = 32'hA5000000 | 32'(exp_addr);
            fetch_word(word, 0, a);
            checks++;
            if (a !== 17'(exp_addr)) begin
                errors++;
                $display("[TB] FAIL stream_addr: got %0d required %0d", a, exp_addr);
            end
            checks++;
            if (buf_load !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stream_dup: buf_load=%b required 0 at addr %0d", buf_load, exp_addr);
            end
            step();
            checks++;
            if (buf_load !== 1'b1 || buf_data !== word) begin
                errors++;
                $display("[TB] FAIL stream_load: load=%b data=%h required 1 %h", buf_load, buf_data, word);
            end
        end
    endtask

    task automatic test_frame_start_pending();
        logic [16:0] a;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 17'd500) begin
            errors++;
            $display("[TB] FAIL pending_setup: req=%b addr=%0d required 1 500", mem_req, mem_addr);
        end
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 17'd500) begin
            errors++;
            $display("[TB] FAIL pending_hold: req=%b addr=%0d required 1 500", mem_req, mem_addr);
        end
        repeat (2) step();
        mem_ack   = 1'b1;
        mem_rdata = 32'h11223344;
        step();
        mem_ack = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== 17'd0 || buf_load !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pending_discard: req=%b addr=%0d load=%b required 0 0 0", mem_req, mem_addr, buf_load);
        end
        step();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 17'd0 || buf_load !== 1'b0) begin
            errors++;
            $display("[TB] FAIL restart_req: req=%b addr=%0d load=%b required 1 0 0", mem_req, mem_addr, buf_load);
        end
        fetch_word(32'h55AA0000, 0, a);
        step();
        checks++;
        if (buf_load !== 1'b1 || buf_data !== 32'h55AA0000 || mem_addr !== 17'd1) begin
            errors++;
            $display("[TB] FAIL restart_load: load=%b data=%h addr=%0d required 1 55aa0000 1",
                     buf_load, buf_data, mem_addr);
        end
    endtask

    task automatic test_frame_start_ack();
        mem_ack     = 1'b1;
        mem_rdata   = 32'hCAFEF00D;
        frame_start = 1'b1;
        step();
        mem_ack     = 1'b0;
        frame_start = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== 17'd0 || dut.hold_valid !== 1'b0 || buf_load !== 1'b0) begin
            errors++;
            $display("[TB] FAIL coincident_ack: req=%b addr=%0d hold_valid=%b load=%b required 0 0 0 0",
                     mem_req, mem_addr, dut.hold_valid, buf_load);
        end
        step();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 17'd0 || buf_load !== 1'b0 || buf_data !== 32'h55AA0000) begin
            errors++;
            $display("[TB] FAIL coincident_next: req=%b addr=%0d load=%b data=%h required 1 0 0 55aa0000",
                     mem_req, mem_addr, buf_load, buf_data);
        end
    endtask

    task automatic test_underrun();
        logic [16:0] a;
        reset     = 1'b1;
        buf_empty = 1'b0;
        mem_ack   = 1'b0;
        step();
        reset = 1'b0;
        fetch_word(32'h00000077, 0, a);
        checks++;
        if (underrun !== 1'b0 || buf_load !== 1'b0) begin
            errors++;
            $display("[TB] FAIL underrun_clean: underrun=%b load=%b required 0 0", underrun, buf_load);
        end
        buf_empty = 1'b1;
        step();
        checks++;
        if (buf_load !== 1'b1 || underrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL underrun_load_cycle: load=%b underrun=%b required 1 0", buf_load, underrun);
        end
        step();
        step();
        checks++;
        if (underrun !== 1'b1) begin
            errors++;
            $display("[TB] FAIL underrun_set: underrun=%b required 1", underrun);
        end
        repeat (19) step();
        buf_empty = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h00000088;
        step();
        mem_ack = 1'b0;
        checks++;
        if (underrun !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL underrun_sticky: underrun=%b req=%b required 1 0", underrun, mem_req);
        end
`ifdef VIDEO_FETCH_UNDERRUN_CNT_EN
        checks++;
        if (underrun_cnt !== 16'd20) begin
            errors++;
            $display("[TB] FAIL underrun_cnt: got %0d required 20", underrun_cnt);
        end
`endif
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        repeat (3) step();
        checks++;
        if (underrun !== 1'b1) begin
            errors++;
            $display("[TB] FAIL underrun_after_frame: underrun=%b required 1", underrun);
        end
`ifdef VIDEO_FETCH_UNDERRUN_CNT_EN
        checks++;
        if (underrun_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL underrun_cnt_clear: got %0d required 0", underrun_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_single_load();
        test_stream(2, TB_FRAME_WORDS);
        test_stream(2, 498);
        test_frame_start_pending();
        test_frame_start_ack();
        test_underrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
